// File: rtl/cu_command_arbiter_pkg.sv
// Shared payload type for the compute-unit command streams and the PSL command port.
package cu_command_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [12:0] cmd_code;
    logic [7:0]  tag;
    logic [11:0] size;
    logic [63:0] address;
  } CommandBufferLine;

endpackage

// File: rtl/cu_command_arbiter.sv
// Buffers four compute-unit command streams in per-stream FIFOs and merges them onto
// one PSL command port through a credit-gated round-robin arbiter.
module cu_command_arbiter
  import cu_command_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned ALFULL_MARGIN = 4,
  parameter int unsigned CREDIT_WIDTH  = 8
) (
  input  logic                    clock,
  input  logic                    rstn,
  input  logic                    enabled_in,
  input  CommandBufferLine        read_command_in,
  input  CommandBufferLine        write_command_in,
  input  CommandBufferLine        prefetch_read_command_in,
  input  CommandBufferLine        prefetch_write_command_in,
  input  logic [CREDIT_WIDTH-1:0] credit_init_in,
  input  logic                    credit_load_in,
  input  logic                    credit_return_in,
  output CommandBufferLine        command_out,
  output logic [0:3]              buffer_empty_out,
  output logic [0:3]              buffer_alfull_out,
  output logic [0:3]              buffer_full_out,
  output logic [0:3]              overflow_out,
  output logic [CREDIT_WIDTH-1:0] credits_out
);

  localparam int unsigned NUM_STREAMS = 4;
  localparam int unsigned ADDR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W       = ADDR_W + 1;
  localparam logic [PTR_W-1:0]        ALFULL_LEVEL = PTR_W'(FIFO_DEPTH - ALFULL_MARGIN);
  localparam logic [PTR_W-1:0]        FULL_LEVEL   = PTR_W'(FIFO_DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX   = '1;

  CommandBufferLine                    push_line_c [NUM_STREAMS];
  CommandBufferLine                    mem_q [NUM_STREAMS][FIFO_DEPTH];
  CommandBufferLine                    head_c;
  CommandBufferLine                    cmd_q, cmd_d;
  logic [NUM_STREAMS-1:0][PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [NUM_STREAMS-1:0][PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [0:NUM_STREAMS-1]              empty_c, full_c, push_c, pop_c;
  logic [0:NUM_STREAMS-1]              empty_q, empty_d, alfull_q, alfull_d;
  logic [0:NUM_STREAMS-1]              full_q, full_d, ovf_q, ovf_d;
  logic [1:0]                          last_q, last_d, winner_c;
  logic                                grant_c;
  logic [CREDIT_WIDTH-1:0]             credits_q, credits_d;

  // Current occupancy view from the pointers, used by the arbiter and push gating.
  always_comb begin
    push_line_c[0] = read_command_in;
    push_line_c[1] = write_command_in;
    push_line_c[2] = prefetch_read_command_in;
    push_line_c[3] = prefetch_write_command_in;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      empty_c[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_c[i]  = (wr_ptr_q[i][PTR_W-1] != rd_ptr_q[i][PTR_W-1]) &&
                   (wr_ptr_q[i][ADDR_W-1:0] == rd_ptr_q[i][ADDR_W-1:0]);
    end
  end

  // Round-robin search starting one past the last winner; a credit load blocks the grant.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    found    = 1'b0;
    cand     = last_q;
    winner_c = last_q;
    grant_c  = enabled_in && !credit_load_in && (credits_q != '0) && !(&empty_c);
    for (int unsigned k = 1; k <= NUM_STREAMS; k++) begin
      cand = last_q + 2'(k);
      if (!found && !empty_c[cand]) begin
        found    = 1'b1;
        winner_c = cand;
      end
    end
  end

  // Next-state: FIFO pointers, status flags, grant register, credits.
  always_comb begin
    logic             push_req;
    logic [PTR_W-1:0] occ;
    pop_c     = '0;
    push_req  = 1'b0;
    occ       = '0;
    ovf_d     = ovf_q;
    last_d    = last_q;
    cmd_d     = '0;
    credits_d = credits_q;
    head_c    = mem_q[winner_c][rd_ptr_q[winner_c][ADDR_W-1:0]];

    if (grant_c) begin
      pop_c[winner_c] = 1'b1;
      last_d          = winner_c;
      cmd_d           = head_c;
      cmd_d.valid     = 1'b1;
    end

    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      push_req    = enabled_in && push_line_c[i].valid;
      // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
      push_c[i]   = push_req && (!full_c[i] || pop_c[i]);
      if (push_req && full_c[i] && !pop_c[i]) begin
        ovf_d[i] = 1'b1;
      end
      wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push_c[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop_c[i]);
      occ         = wr_ptr_d[i] - rd_ptr_d[i];
      empty_d[i]  = (occ == '0);
      alfull_d[i] = (occ >= ALFULL_LEVEL);
      full_d[i]   = (occ == FULL_LEVEL);
    end

    if (credit_load_in) begin
      credits_d = credit_init_in;
    end else if (grant_c && credit_return_in) begin
      credits_d = credits_q;
    end else if (grant_c) begin
      credits_d = credits_q - CREDIT_WIDTH'(1);
    end else if (credit_return_in && (credits_q != CREDIT_MAX)) begin
      credits_d = credits_q + CREDIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      empty_q   <= '1;
      alfull_q  <= '0;
      full_q    <= '0;
      ovf_q     <= '0;
      last_q    <= 2'd3;
      cmd_q     <= '0;
      credits_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      empty_q   <= empty_d;
      alfull_q  <= alfull_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      credits_q <= credits_d;
    end
  end

  // Payload storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      if (push_c[i]) begin
        mem_q[i][wr_ptr_q[i][ADDR_W-1:0]] <= push_line_c[i];
      end
    end
  end

  assign command_out       = cmd_q;
  assign buffer_empty_out  = empty_q;
  assign buffer_alfull_out = alfull_q;
  assign buffer_full_out   = full_q;
  assign overflow_out      = ovf_q;
  assign credits_out       = credits_q;

endmodule

// File: tb/tb_cu_command_arbiter.sv
// Bench for cu_command_arbiter: directed vector table, corner sequences, and random
// traffic checked against a queue-based reference model.
module tb_cu_command_arbiter;
  import cu_command_arbiter_pkg::*;

  localparam int DEPTH = 16;
  localparam int ALF   = 12;

  logic             clock;
  logic             rstn;
  logic             en;
  logic             load;
  logic             ret;
  logic [7:0]       init;
  CommandBufferLine in_line [4];
  CommandBufferLine cmd_o;
  logic [0:3]       empty_o, alfull_o, full_o, ovf_o;
  logic [7:0]       cred_o;

  int errors = 0;
  int checks = 0;
  int tagn   = 0;

  // Reference model state
  CommandBufferLine mq [4][$];
  CommandBufferLine m_cmd;
  int               m_cred;
  int               m_last;
  logic [3:0]       m_ovf;

  typedef struct {
    logic        en;
    logic [3:0]  push;
    logic [63:0] addr;
    logic        load;
    logic [7:0]  init;
    logic        ret;
    logic        exp_valid;
    logic [63:0] exp_addr;
    logic [7:0]  exp_cred;
    logic [3:0]  exp_empty;
  } vec_t;

  vec_t tbl [18];

  cu_command_arbiter dut (
    .clock                     (clock),
    .rstn                      (rstn),
    .enabled_in                (en),
    .read_command_in           (in_line[0]),
    .write_command_in          (in_line[1]),
    .prefetch_read_command_in  (in_line[2]),
    .prefetch_write_command_in (in_line[3]),
    .credit_init_in            (init),
    .credit_load_in            (load),
    .credit_return_in          (ret),
    .command_out               (cmd_o),
    .buffer_empty_out          (empty_o),
    .buffer_alfull_out         (alfull_o),
    .buffer_full_out           (full_o),
    .overflow_out              (ovf_o),
    .credits_out               (cred_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] rev(input logic [0:3] x);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = x[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_push(input logic [3:0] mask, input logic [63:0] addr);
    for (int i = 0; i < 4; i++) begin
      in_line[i] = '0;
      if (mask[i]) begin
        in_line[i].valid    = 1'b1;
        in_line[i].cmd_code = 13'(i + 1);
        in_line[i].tag      = 8'(tagn);
        in_line[i].size     = 12'd128;
        in_line[i].address  = addr + 64'(i * 256);
        tagn++;
      end
    end
  endtask

  task automatic set_idle();
    set_push(4'b0000, 64'h0);
    load = 1'b0;
    ret  = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_cmd  = '0;
    m_cred = 0;
    m_last = 3;
    m_ovf  = '0;
  endtask

  // One clock edge of the behavioural model, from the inputs currently driven.
  task automatic model_step();
    bit g;
    int w;
    g = 0;
    w = 0;
    if (en && m_cred > 0 && !load) begin
      for (int k = 1; k <= 4; k++) begin
        int s;
        s = (m_last + k) % 4;
        if (!g && mq[s].size() != 0) begin
          g = 1;
          w = s;
        end
      end
    end
    m_cmd = '0;
    if (g) begin
      m_cmd       = mq[w].pop_front();
      m_cmd.valid = 1'b1;
      m_last      = w;
    end
    for (int i = 0; i < 4; i++) begin
      if (en && in_line[i].valid) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(in_line[i]);
        else m_ovf[i] = 1'b1;
      end
    end
    if (load) m_cred = int'(init);
    else if (g && ret) m_cred = m_cred;
    else if (g) m_cred = m_cred - 1;
    else if (ret) m_cred = (m_cred < 255) ? m_cred + 1 : 255;
  endtask

  task automatic compare_model();
    logic [3:0] e_empty, e_alf, e_full;
    for (int i = 0; i < 4; i++) begin
      e_empty[i] = (mq[i].size() == 0);
      e_alf[i]   = (mq[i].size() >= ALF);
      e_full[i]  = (mq[i].size() == DEPTH);
    end
    chk("command_out", 128'(cmd_o), 128'(m_cmd));
    chk("credits_out", 128'(cred_o), 128'(m_cred));
    chk("buffer_empty_out", 128'(rev(empty_o)), 128'(e_empty));
    chk("buffer_alfull_out", 128'(rev(alfull_o)), 128'(e_alf));
    chk("buffer_full_out", 128'(rev(full_o)), 128'(e_full));
    chk("overflow_out", 128'(rev(ovf_o)), 128'(m_ovf));
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en   = 1'b1;
    set_idle();
    init = 8'd0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    rstn = 1'b1;
    compare_model();
  endtask

  initial begin
    int issued;
    clock = 1'b0;
    rstn  = 1'b0;
    en    = 1'b0;
    init  = 8'd0;
    set_idle();

    //                en    push     addr        ld    init  ret   v     exp_addr    cred   empty
    tbl[0]  = '{1'b1, 4'b0000, 64'h0,    1'b1, 8'd8,   1'b0, 1'b0, 64'h0,    8'd8,   4'b1111};
    tbl[1]  = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b0, 1'b0, 64'h0,    8'd8,   4'b1111};
    tbl[2]  = '{1'b1, 4'b1111, 64'h2000, 1'b0, 8'd0,   1'b0, 1'b0, 64'h0,    8'd8,   4'b0000};
    tbl[3]  = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b0, 1'b1, 64'h2000, 8'd7,   4'b0001};
    tbl[4]  = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b0, 1'b1, 64'h2100, 8'd6,   4'b0011};
    tbl[5]  = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b0, 1'b1, 64'h2200, 8'd5,   4'b0111};
    tbl[6]  = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b0, 1'b1, 64'h2300, 8'd4,   4'b1111};
    tbl[7]  = '{1'b1, 4'b0001, 64'h1000, 1'b0, 8'd0,   1'b0, 1'b0, 64'h0,    8'd4,   4'b1110};
    tbl[8]  = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b0, 1'b1, 64'h1000, 8'd3,   4'b1111};
    tbl[9]  = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b0, 1'b0, 64'h0,    8'd3,   4'b1111};
    tbl[10] = '{1'b0, 4'b0001, 64'h3000, 1'b0, 8'd0,   1'b0, 1'b0, 64'h0,    8'd3,   4'b1111};
    tbl[11] = '{1'b0, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b1, 1'b0, 64'h0,    8'd4,   4'b1111};
    tbl[12] = '{1'b1, 4'b0010, 64'h4000, 1'b0, 8'd0,   1'b0, 1'b0, 64'h0,    8'd4,   4'b1101};
    tbl[13] = '{1'b0, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b0, 1'b0, 64'h0,    8'd4,   4'b1101};
    tbl[14] = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b0, 1'b1, 64'h4100, 8'd3,   4'b1111};
    tbl[15] = '{1'b1, 4'b0000, 64'h0,    1'b1, 8'd254, 1'b0, 1'b0, 64'h0,    8'd254, 4'b1111};
    tbl[16] = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b1, 1'b0, 64'h0,    8'd255, 4'b1111};
    tbl[17] = '{1'b1, 4'b0000, 64'h0,    1'b0, 8'd0,   1'b1, 1'b0, 64'h0,    8'd255, 4'b1111};

    // Reset state, then the directed vector table
    do_reset();
    for (int v = 0; v < 18; v++) begin
      en   = tbl[v].en;
      set_push(tbl[v].push, tbl[v].addr);
      load = tbl[v].load;
      init = tbl[v].init;
      ret  = tbl[v].ret;
      step();
      chk($sformatf("vec%0d valid", v), 128'(cmd_o.valid), 128'(tbl[v].exp_valid));
      chk($sformatf("vec%0d addr", v), 128'(cmd_o.address), 128'(tbl[v].exp_addr));
      chk($sformatf("vec%0d credits", v), 128'(cred_o), 128'(tbl[v].exp_cred));
      chk($sformatf("vec%0d empty", v), 128'(rev(empty_o)), 128'(tbl[v].exp_empty));
    end

    // Credit starvation: 2 credits, 5 write commands
    do_reset();
    load = 1'b1; init = 8'd2; step();
    set_idle();
    issued = 0;
    for (int n = 0; n < 5; n++) begin
      set_push(4'b0010, 64'h5000 + 64'(n * 16));
      step();
      if (cmd_o.valid) issued++;
    end
    set_idle();
    for (int n = 0; n < 3; n++) begin
      step();
      if (cmd_o.valid) issued++;
    end
    chk("starve issued_before_return", 128'(issued), 128'(2));
    chk("starve idle command_out", 128'(cmd_o), 128'(0));
    for (int n = 0; n < 3; n++) begin
      ret = 1'b1; step(); if (cmd_o.valid) issued++;
      ret = 1'b0; step(); if (cmd_o.valid) issued++;
    end
    step(); if (cmd_o.valid) issued++;
    chk("starve issued_total", 128'(issued), 128'(5));
    chk("starve final credits", 128'(cred_o), 128'(0));

    // Overflow: no credits, FIFO_DEPTH + 1 prefetch-write pushes
    do_reset();
    for (int k = 1; k <= DEPTH + 1; k++) begin
      set_push(4'b1000, 64'h6000 + 64'(k * 64));
      step();
      chk($sformatf("ovf alfull3 after %0d", k), 128'(alfull_o[3]), 128'(k >= ALF));
      chk($sformatf("ovf full3 after %0d", k), 128'(full_o[3]), 128'(k >= DEPTH));
      chk($sformatf("ovf flag3 after %0d", k), 128'(ovf_o[3]), 128'(k > DEPTH));
    end
    set_idle();
    load = 1'b1; init = 8'd20; step();
    load = 1'b0;
    issued = 0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (cmd_o.valid) issued++;
    end
    chk("ovf issued", 128'(issued), 128'(DEPTH));
    chk("ovf credits left", 128'(cred_o), 128'(4));
    chk("ovf sticky", 128'(ovf_o[3]), 128'(1));

    // Full FIFO with same-cycle pop and push: accepted, no overflow
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      set_push(4'b0100, 64'h7000 + 64'(k));
      step();
    end
    set_idle();
    load = 1'b1; init = 8'd3; step();
    set_push(4'b0100, 64'h7F00); load = 1'b0; step();
    chk("fullpop overflow", 128'(ovf_o[2]), 128'(0));
    chk("fullpop still full", 128'(full_o[2]), 128'(1));

    // Grant, return and push on the same stream in one cycle
    do_reset();
    load = 1'b1; init = 8'd5; step();
    load = 1'b0;
    set_push(4'b0001, 64'h8000); step();
    set_push(4'b0001, 64'h8100); step();
    set_push(4'b0001, 64'h8200); ret = 1'b1; step();
    chk("simul credits unchanged", 128'(cred_o), 128'(4));
    chk("simul granted", 128'(cmd_o.valid), 128'(1));
    chk("simul stream0 nonempty", 128'(empty_o[0]), 128'(0));
    ret = 1'b0;

    // Asynchronous reset in the middle of a burst
    for (int n = 0; n < 3; n++) begin
      set_push(4'b1111, 64'h9000 + 64'(n * 4096));
      step();
    end
    #3;
    rstn = 1'b0;
    set_idle();
    model_reset();
    #1;
    compare_model();
    chk("areset last-grant via empty", 128'(rev(empty_o)), 128'(4'b1111));
    @(posedge clock);
    #1;
    rstn = 1'b1;
    for (int n = 0; n < 4; n++) step();

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 9) != 0);
      set_push(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
               {32'($urandom), 32'($urandom)});
      load = ($urandom_range(0, 39) == 0);
      init = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(250, 255))
                                         : 8'($urandom_range(0, 20));
      ret  = ($urandom_range(0, 9) < 3);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cu_command_arbiter.md
# cu_command_arbiter

Merges the four per-compute-unit command streams (read, write, prefetch-read, prefetch-write) into a single PSL command port. It sits directly downstream of the compute-unit control block. Each stream is buffered in its own FIFO. A round-robin arbiter drains the FIFOs, gated by a PSL command-credit counter. Per-stream buffer status is fed back upstream so the data engines throttle before overflow.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: entries per stream FIFO; power of two, ≥4.
- `ALFULL_MARGIN`, 4: almost-full asserts at occupancy ≥ `FIFO_DEPTH - ALFULL_MARGIN`.
- `CREDIT_WIDTH`, 8: width of the command-credit counter.

Ports:
- `clock`  in  1  — single clock; all state is on its rising edge.
- `rstn`  in  1  — asynchronous, active-low reset.
- `enabled_in`  in  1  — block enable.
- `read_command_in`  in  CommandBufferLine  — stream 0; entry valid when `.valid` = 1.
- `write_command_in`  in  CommandBufferLine  — stream 1.
- `prefetch_read_command_in`  in  CommandBufferLine  — stream 2.
- `prefetch_write_command_in`  in  CommandBufferLine  — stream 3.
- `credit_init_in`  in  CREDIT_WIDTH  — initial credit value (PSL croom).
- `credit_load_in`  in  1  — loads `credit_init_in` into the credit counter.
- `credit_return_in`  in  1  — one command response received; returns one credit.
- `command_out`  out  CommandBufferLine  — granted command; registered.
- `buffer_empty_out`  out  [0:3]  — per-stream FIFO empty flag.
- `buffer_alfull_out`  out  [0:3]  — per-stream almost-full flag.
- `buffer_full_out`  out  [0:3]  — per-stream full flag.
- `overflow_out`  out  [0:3]  — sticky: a command arrived while that stream's FIFO was full.
- `credits_out`  out  CREDIT_WIDTH  — current credit count.

## Operation
Stream index order: 0 = read, 1 = write, 2 = prefetch-read, 3 = prefetch-write.

Push:
- When `enabled_in` = 1 and `stream.valid` = 1, the line is written into that stream's FIFO at the clock edge.
- If the FIFO is full, the command is dropped and `overflow_out[i]` is set. It stays set until reset.

Arbitration:
- The arbiter is combinational over the FIFO empty flags, with a registered last-grant pointer (reset value 3).
- A grant requires all of: `enabled_in` = 1, credits > 0, and at least one FIFO non-empty.
- On a grant, the winner is the first non-empty stream searching from (last-grant + 1) mod 4 upward, wrapping around.
- The winner's FIFO pops, its head is registered into `command_out` with `.valid` = 1, and the last-grant pointer updates to the winner.
- Without a grant, `command_out` is driven to all-zero on the next edge. Stale payload is never presented.

Credits, in priority order:
1. `credit_load_in`: counter ← `credit_init_in`. Any same-cycle grant or return is ignored for the count. The grant is still suppressed that cycle.
2. Grant and return in the same cycle: count is unchanged.
3. Grant only: count − 1.
4. Return only: count + 1, saturating at 2^CREDIT_WIDTH − 1.

A grant can never drive the count below 0.

Enable:
- `enabled_in` = 0 blocks pushes and grants, and registers `command_out` to 0.
- FIFO contents, the credit count, and the pointer are all retained.
- Credit load and credit return stay active regardless of `enabled_in`.

FIFO implementation:
- Circular buffer with read/write pointers of log2(FIFO_DEPTH) + 1 bits.
- Empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
- Push and pop in the same cycle on a full FIFO: the pop happens first, the push is accepted, and there is no overflow.
- Push and pop in the same cycle on an empty FIFO: the push is accepted and the pop does not occur (nothing was granted).

## Timing
- Reset values:
  - `command_out` = 0, `credits_out` = 0
  - `buffer_empty_out` = 4'b1111
  - `buffer_alfull_out`, `buffer_full_out`, `overflow_out` = 0
  - All FIFO pointers = 0, last-grant pointer = 3
- Reset asserted mid-operation clears all queued commands immediately. No command is presented after reset deasserts until a new push occurs and credits are loaded.
- Latency:
  - A push sampled at edge N is visible as non-empty at cycle N+1.
  - At the earliest, it is granted at cycle N+1 and appears on `command_out` after edge N+1.
  - Minimum latency is 2 cycles.
- Throughput: one command per cycle while credits > 0.
- Status flags are registered and reflect occupancy after the current edge.
- `credits_out` updates on the same edge as the grant.

## Test plan
- **Reset and idle.** Reset, then load credits = 8 with all streams idle → `command_out` stays 0, `credits_out` = 8, `buffer_empty_out` = 1111.
- **Single command.** Credits = 8; push one read command with address 0x1000 → `command_out.valid` = 1 with address 0x1000 exactly 2 cycles later; `credits_out` = 7.
- **Round-robin.** Push one command on all four streams in the same cycle → grants appear on consecutive cycles in order 0, 1, 2, 3; a subsequent lone stream-0 push is granted next.
- **Credit starvation.** Credits = 2; push 5 write commands → exactly 2 issued, then `command_out` = 0. Pulse `credit_return_in` 3 times → remaining 3 issued; final `credits_out` = 0.
- **Overflow.** Credits = 0; push `FIFO_DEPTH` + 1 prefetch-write commands → `buffer_alfull_out[3]` rises after entry 12; `buffer_full_out[3]` rises after entry 16; `overflow_out[3]` = 1; only 16 commands are issued after credits are loaded.
- **Simultaneous events.** Grant, return and push on the same stream in one cycle → credits unchanged, FIFO occupancy unchanged. Then assert `rstn` low mid-burst → all outputs return to their reset values asynchronously.
